// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter: FSM encoding, bus width and select decode.
// The decode returns a wide one-hot that callers truncate to their register count.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } bus_state_t;

  localparam int BUS_W   = 16;
  localparam int MAX_REG = 256;

  function automatic logic sel_in_range(input int unsigned idx, input int unsigned num_reg);
    return idx < num_reg;
  endfunction

  // Out-of-range selects decode to all-zero so no register is ever enabled.
  function automatic logic [MAX_REG-1:0] sel_decode(input int unsigned idx, input int unsigned num_reg);
    logic [MAX_REG-1:0] oh;
    oh = '0;
    if (sel_in_range(idx, num_reg) && idx < MAX_REG)
      oh = {{(MAX_REG-1){1'b0}}, 1'b1} << idx;
    return oh;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr, wrapping.
// Zero latency; no flow control of its own, the caller decides when to take the pick.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk distances from farthest to nearest so the requester closest to ptr is written last.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;
  assign gnt = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer for the shared register bus: IDLE -> READ -> WRITE, one move per 3 cycles.
// Grant/read_en one cycle after req is seen, write_en/done one cycle later; requests wait while busy.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int SEL_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] src_sel,
  input  logic [NUM_REQ*SEL_W-1:0] dst_sel,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [NUM_REG-1:0]       read_en,
  output logic [NUM_REG-1:0]       write_en,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bus_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [SEL_W-1:0]   dst_q;
  logic               bad_q;

  logic [SEL_W-1:0]   src_arr [NUM_REQ];
  logic [SEL_W-1:0]   dst_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_src;
  logic [SEL_W-1:0]   pick_dst;
  logic               pick_ok;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_arr[i] = src_sel[i*SEL_W +: SEL_W];
    assign dst_arr[i] = dst_sel[i*SEL_W +: SEL_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_src = src_arr[pick_idx];
  assign pick_dst = dst_arr[pick_idx];
  assign pick_ok  = sel_in_range(32'(pick_src), NUM_REG) && sel_in_range(32'(pick_dst), NUM_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      dst_q    <= '0;
      bad_q    <= 1'b0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      read_en  <= '0;
      write_en <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gidx    <= pick_idx;
            dst_q   <= pick_dst;
            bad_q   <= !pick_ok;
            grant   <= pick_gnt;
            busy    <= 1'b1;
            // A bad select on either side suppresses both enables for the whole move.
            read_en <= pick_ok ? NUM_REG'(sel_decode(32'(pick_src), NUM_REG)) : '0;
            state   <= READ;
          end
        end
        READ: begin
          write_en <= bad_q ? '0 : NUM_REG'(sel_decode(32'(dst_q), NUM_REG));
          done     <= grant;
          err      <= bad_q;
          state    <= WRITE;
        end
        WRITE: begin
          grant    <= '0;
          busy     <= 1'b0;
          done     <= '0;
          err      <= 1'b0;
          read_en  <= '0;
          write_en <= '0;
          ptr      <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomised and directed bench for reg_bus_arbiter with a transaction-level scoreboard
// and a behavioural register file driven by the DUT enables.
module tb_reg_bus_arbiter;
  import reg_bus_pkg::*;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int SW   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*SW-1:0] src_sel = '0;
  logic [NREQ*SW-1:0] dst_sel = '0;
  logic [NREQ-1:0]   grant, done;
  logic              err, busy;
  logic [NREG-1:0]   read_en, write_en;

  reg_bus_arbiter #(.NUM_REQ(NREQ), .NUM_REG(NREG), .SEL_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .src_sel  (src_sel),
    .dst_sel  (dst_sel),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .read_en  (read_en),
    .write_en (write_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int who;
    int src;
    int dst;
    int t_dec;
  } xact_t;

  xact_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    m_ptr = 0;
  int    m_wait = 0;
  int    done_cnt [NREQ] = '{default: 0};
  logic [NREQ-1:0] auto_drop = '0;
  bit    mon_en = 1'b0;

  logic [BUS_W-1:0] bus_reg [NREG];
  logic [BUS_W-1:0] exp_reg [NREG];
  bit loaded = 1'b0;

  always @(posedge clk) cyc++;

  // Register file: whichever register has read_en drives the bus, write_en registers capture it.
  always @(posedge clk) begin
    logic [BUS_W-1:0] bus;
    if (!loaded) begin
      loaded <= 1'b1;
      for (int r = 0; r < NREG; r++) bus_reg[r] <= BUS_W'($urandom);
    end else begin
      bus = 'z;
      for (int r = 0; r < NREG; r++) if (read_en[r]) bus = bus_reg[r];
      for (int r = 0; r < NREG; r++) if (write_en[r]) bus_reg[r] <= bus;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] exp_re(input xact_t e);
    return (e.src < NREG && e.dst < NREG) ? (32'(1) << e.src) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_we(input xact_t e);
    return (e.src < NREG && e.dst < NREG) ? (32'(1) << e.dst) : 32'd0;
  endfunction

  // Transaction model: the bus is free every third cycle; a free cycle with any request
  // hands the bus to the first requester at or after the rotating pointer.
  task automatic model_step();
    xact_t e;
    int w;
    if (rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_wait = 0;
      return;
    end
    if (m_wait > 0) begin
      m_wait--;
      return;
    end
    for (int k = 0; k < NREQ; k++) begin
      w = (m_ptr + k) % NREQ;
      if (req[w]) begin
        e.who   = w;
        e.src   = int'(src_sel[w*SW +: SW]);
        e.dst   = int'(dst_sel[w*SW +: SW]);
        e.t_dec = cyc;
        exp_q.push_back(e);
        m_ptr  = (w + 1) % NREQ;
        m_wait = 2;
        return;
      end
    end
  endtask

  // Monitor / scoreboard
  logic [NREQ-1:0] prev_grant = '0;
  bit chk_regs = 1'b0;

  always @(negedge clk) begin
    xact_t e;
    if (!mon_en) begin
      for (int r = 0; r < NREG; r++) exp_reg[r] = bus_reg[r];
      prev_grant = '0;
      chk_regs   = 1'b0;
    end else begin
      if (chk_regs) begin
        chk_regs = 1'b0;
        for (int r = 0; r < NREG; r++) chk($sformatf("reg%0d_value", r), 32'(bus_reg[r]), 32'(exp_reg[r]));
      end
      chk("grant_onehot", $countones(grant) <= 1, 1);
      chk("read_en_onehot", $countones(read_en) <= 1, 1);
      chk("write_en_onehot", $countones(write_en) <= 1, 1);
      chk("write_needs_read", (write_en == '0) || (read_en != '0), 1);
      chk("busy_vs_grant", busy, |grant);
      chk("idle_no_enables", (grant != '0) || (read_en == '0 && write_en == '0), 1);
      chk("err_only_with_done", !err || (done != '0), 1);

      if (grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 32'(grant), 0);
        end else begin
          e = exp_q[0];
          chk("grant_who", 32'(grant), 32'(1) << e.who);
          chk("grant_read_en", 32'(read_en), exp_re(e));
          chk("grant_latency", cyc, e.t_dec + 1);
        end
      end

      if (done != '0) begin
        for (int i = 0; i < NREQ; i++) if (done[i]) done_cnt[i]++;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_who", 32'(done), 32'(1) << e.who);
          chk("done_grant", 32'(grant), 32'(1) << e.who);
          chk("done_err", err, (e.src >= NREG || e.dst >= NREG));
          chk("done_read_en", 32'(read_en), exp_re(e));
          chk("done_write_en", 32'(write_en), exp_we(e));
          chk("done_latency", cyc, e.t_dec + 2);
          if (e.src < NREG && e.dst < NREG) exp_reg[e.dst] = exp_reg[e.src];
          chk_regs = 1'b1;
        end
      end
      prev_grant = grant;
    end
  end

  // Driver
  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
    req = req & ~(done & auto_drop);
  endtask

  task automatic set_sel(input int i, input int s, input int d);
    src_sel[i*SW +: SW] = SW'(s);
    dst_sel[i*SW +: SW] = SW'(d);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_read_en"}, 32'(read_en), 0);
    chk({nm, "_write_en"}, 32'(write_en), 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic run_until_idle(input string nm);
    int n;
    n = 0;
    while (!(req == '0 && m_wait == 0 && exp_q.size() == 0) && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_completed"}, n < 60, 1);
  endtask

  initial begin
    int base [NREQ];

    do_reset(3);
    check_all_zero("reset");
    mon_en = 1'b1;

    // single transfer reg2 -> reg5
    auto_drop = '1;
    set_sel(0, 2, 5);
    req = 4'b0001;
    run_until_idle("single");

    // src == dst
    set_sel(3, 3, 3);
    req = 4'b1000;
    run_until_idle("same_reg");

    // out-of-range source, then out-of-range destination
    set_sel(0, 7, 1);
    set_sel(1, 2, 6);
    req = 4'b0011;
    run_until_idle("out_of_range");

    // contention from reset, requests held across three transfers
    do_reset(2);
    auto_drop = '0;
    base = done_cnt;
    set_sel(1, 0, 3);
    set_sel(3, 4, 2);
    req = 4'b1010;
    repeat (9) tick();
    req = '0;
    repeat (3) tick();
    chk("contention_done1", done_cnt[1] - base[1], 2);
    chk("contention_done3", done_cnt[3] - base[3], 1);

    // fairness: all requests held for twelve transfers
    do_reset(2);
    base = done_cnt;
    for (int i = 0; i < NREQ; i++) set_sel(i, $urandom_range(NREG - 1), $urandom_range(NREG - 1));
    req = '1;
    repeat (36) tick();
    req = '0;
    repeat (3) tick();
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_done%0d", i), done_cnt[i] - base[i], 3);

    // reset asserted during READ
    do_reset(2);
    auto_drop = '1;
    set_sel(1, 0, 4);
    req = 4'b0010;
    tick();
    chk("midop_busy_in_read", busy, 1);
    rst = 1'b1;
    req = '0;
    tick();
    check_all_zero("midop_rst");
    rst = 1'b0;
    set_sel(2, 4, 0);
    req = 4'b0100;
    run_until_idle("after_midop_rst");

    // random traffic with drops, re-requests and select changes
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            set_sel(i, $urandom_range(7), $urandom_range(7));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(29) == 0) set_sel(i, $urandom_range(7), $urandom_range(7));
      end
      tick();
    end

    req = '0;
    repeat (6) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
